clk_div_ctrl: RTL



---
 rtl/clk_div_pkg.sv | 9 +
 rtl/clk_div_if.sv | 18 +
 rtl/clk_div_core.sv | 29 ++
 rtl/clk_div_ctrl.sv | 69 ++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared widths, reset half-period and FSM state codes for the clock divider
package clk_div_pkg;
   localparam int CNT_W = 8;
   localparam int DEFAULT_HALF = 3;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN = 2'd1;
   localparam logic [1:0] STOPPING = 2'd2;
   typedef logic [1:0] state_t;
endpackage

// File: rtl/clk_div_if.sv
// clk_div_if: control/config bundle (en, cfg_valid/cfg_half/cfg_ready/cfg_err) and status (clk_out, rise_pulse, busy, cur_half); master drives, slave is the divider
interface clk_div_if
   import clk_div_pkg::*;
#(
   parameter int W = CNT_W
);
   logic en;
   logic cfg_valid;
   logic [W-1:0] cfg_half;
   logic cfg_ready;
   logic cfg_err;
   logic clk_out;
   logic rise_pulse;
   logic busy;
   logic [W-1:0] cur_half;
   modport master(output en, cfg_valid, cfg_half, input cfg_ready, cfg_err, clk_out, rise_pulse, busy, cur_half);
   modport slave(input en, cfg_valid, cfg_half, output cfg_ready, cfg_err, clk_out, rise_pulse, busy, cur_half);
endinterface

// File: rtl/clk_div_core.sv
// clk_div_core: half-period counter and toggle; ports clk, reset_n, run, load_half in, clk_out/rise_pulse/fall/cnt_zero out
module clk_div_core #(
   parameter int CNT_W = clk_div_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             run,
   input  logic [CNT_W-1:0] load_half,
   output logic             clk_out,
   output logic             rise_pulse,
   output logic             fall,
   output logic             cnt_zero
);
   logic [CNT_W-1:0] cnt;
   logic hit;
   assign hit = run && cnt == load_half - 1'b1;
   assign fall = hit && clk_out;
   assign cnt_zero = cnt == '0;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         cnt <= '0;
         clk_out <= 1'b0;
         rise_pulse <= 1'b0;
      end else begin
         cnt <= run && !hit ? cnt + 1'b1 : '0;
         clk_out <= run && (clk_out ^ hit);
         rise_pulse <= hit && !clk_out;
      end
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run/stop FSM, config handshake and pending ratio for an even divider; ports clk, reset_n, bus (clk_div_if.slave), period_cnt only with CLK_DIV_PERIOD_CNT_EN
module clk_div_ctrl #(
   parameter int CNT_W = clk_div_pkg::CNT_W,
   parameter int DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF
) (
   input  logic        clk,
   input  logic        reset_n,
`ifdef CLK_DIV_PERIOD_CNT_EN
   output logic [15:0] period_cnt,
`endif
   clk_div_if.slave    bus
);
   import clk_div_pkg::*;
   state_t state, state_nxt;
   logic [CNT_W-1:0] cur_half, pend_half, clamped;
   logic pending, cfg_err, accept, run, fall, cnt_zero, clk_o, rise, to_idle, apply;
   clk_div_core #(.CNT_W(CNT_W)) u_core (
      .clk,
      .reset_n,
      .run,
      .load_half(cur_half),
      .clk_out(clk_o),
      .rise_pulse(rise),
      .fall,
      .cnt_zero
   );
   // a stop parks only once clk_out is already low, so the high phase always completes
   always_comb state_nxt = state == IDLE ? (bus.en ? RUN : IDLE) :
                           state == RUN  ? (bus.en ? RUN : STOPPING) :
                           bus.en ? RUN : clk_o ? STOPPING : IDLE;
   assign run = state == RUN || (state != IDLE && (bus.en || clk_o));
   assign accept = bus.cfg_valid && !pending;
   assign clamped = bus.cfg_half == '0 ? CNT_W'(1) : bus.cfg_half;
   assign to_idle = state != IDLE && state_nxt == IDLE;
   // a new ratio only lands at a phase boundary of the low phase, never mid-pulse
   assign apply = pending && (fall || (!clk_o && cnt_zero) || to_idle);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         pending <= 1'b0;
         pend_half <= CNT_W'(DEFAULT_HALF);
         cur_half <= CNT_W'(DEFAULT_HALF);
         cfg_err <= 1'b0;
      end else begin
         state <= state_nxt;
         cfg_err <= accept && bus.cfg_half == '0;
         if (apply) begin
            cur_half <= pend_half;
            pending <= 1'b0;
         end else if (accept && state == IDLE) begin
            cur_half <= clamped;
         end else if (accept) begin
            pend_half <= clamped;
            pending <= 1'b1;
         end
      end
`ifdef CLK_DIV_PERIOD_CNT_EN
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) period_cnt <= '0;
      else if (to_idle) period_cnt <= '0;
      else if (rise) period_cnt <= period_cnt + 1'b1;
`endif
   assign bus.cfg_ready = !pending;
   assign bus.cfg_err = cfg_err;
   assign bus.clk_out = clk_o;
   assign bus.rise_pulse = rise;
   assign bus.busy = state != IDLE;
   assign bus.cur_half = cur_half;
endmodule
